// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack with in-order checkpoints for one-cycle misprediction recovery.
// Optional RAS_CKPT_TOP_REPAIR_EN: checkpoints also hold the top entry and rewrite it on restore.
module ras_ckpt #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_TARGET_WIDTH = 31,
    parameter int RAS_CKPT_COUNT   = 4,
    localparam int IW = $clog2(RAS_ENTRIES),
    localparam int CW = $clog2(RAS_CKPT_COUNT)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic                        ret_hit,
    output logic [IW-1:0]               ras_ptr,
    input  logic                        ckpt_save_valid,
    output logic [CW-1:0]               ckpt_save_id,
    output logic                        ckpt_full,
    input  logic                        ckpt_free_valid,
    input  logic                        restore_valid,
    input  logic [CW-1:0]               restore_id
);

    localparam logic [IW:0] STACK_FULL = (IW+1)'(RAS_ENTRIES);
    localparam logic [IW:0] CNT_ONE    = (IW+1)'(1);
    localparam logic [CW:0] CKPT_FULL  = (CW+1)'(RAS_CKPT_COUNT);
    localparam logic [CW:0] CKPT_ONE   = (CW+1)'(1);

    logic [RAS_TARGET_WIDTH-1:0] stack [RAS_ENTRIES];
    logic [IW-1:0]               ptr, nxt_ptr, wr_idx;
    logic [IW:0]                 count, nxt_count;
    logic [IW-1:0]               slot_ptr [RAS_CKPT_COUNT];
    logic [IW:0]                 slot_cnt [RAS_CKPT_COUNT];
`ifdef RAS_CKPT_TOP_REPAIR_EN
    logic [RAS_TARGET_WIDTH-1:0] slot_top [RAS_CKPT_COUNT];
    logic [RAS_TARGET_WIDTH-1:0] nxt_top;
`endif
    logic [CW-1:0]               head, tail;
    logic [CW:0]                 ckpt_cnt, nxt_ckpt_cnt;
    logic                        free_ok, save_ok;

    assign ret_target   = stack[ptr];
    assign ret_hit      = (count != '0);
    assign ras_ptr      = ptr;
    assign ckpt_save_id = tail;
    assign ckpt_full    = (ckpt_cnt == CKPT_FULL);

    // Post-update stack pointer/count for this cycle's push/pop; also feeds checkpoint saves.
    always_comb begin
        nxt_ptr   = ptr;
        nxt_count = count;
        wr_idx    = ptr;
        if (push_valid && pop_valid) begin
            if (count == '0) nxt_count = CNT_ONE;
        end else if (push_valid) begin
            nxt_ptr = ptr + 1'b1;
            wr_idx  = ptr + 1'b1;
            if (count != STACK_FULL) nxt_count = count + CNT_ONE;
        end else if (pop_valid && count != '0) begin
            nxt_ptr   = ptr - 1'b1;
            nxt_count = count - CNT_ONE;
        end
    end

`ifdef RAS_CKPT_TOP_REPAIR_EN
    assign nxt_top = push_valid ? push_target : stack[nxt_ptr];
`endif

    // A free in the same cycle vacates the head slot, so a save while full is still accepted then.
    assign free_ok = ckpt_free_valid && (ckpt_cnt != '0);
    assign save_ok = ckpt_save_valid && !restore_valid && (!ckpt_full || free_ok);

    always_comb begin
        if (restore_valid)
            nxt_ckpt_cnt = {1'b0, restore_id - head} + CKPT_ONE;
        else if (save_ok)
            nxt_ckpt_cnt = ckpt_cnt + CKPT_ONE;
        else
            nxt_ckpt_cnt = ckpt_cnt;
        if (free_ok) nxt_ckpt_cnt = nxt_ckpt_cnt - CKPT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) stack[i] <= '0;
            ptr      <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            ckpt_cnt <= '0;
        end else begin
            if (restore_valid) begin
                ptr   <= slot_ptr[restore_id];
                count <= slot_cnt[restore_id];
                tail  <= restore_id + 1'b1;
`ifdef RAS_CKPT_TOP_REPAIR_EN
                stack[slot_ptr[restore_id]] <= slot_top[restore_id];
`endif
            end else begin
                ptr   <= nxt_ptr;
                count <= nxt_count;
                if (push_valid) stack[wr_idx] <= push_target;
                if (save_ok) tail <= tail + 1'b1;
            end
            if (free_ok) head <= head + 1'b1;
            ckpt_cnt <= nxt_ckpt_cnt;
        end
    end

    // Checkpoint slot payload is plain data; only live slots are ever read.
    always_ff @(posedge CLK) begin
        if (!RST && save_ok) begin
            slot_ptr[tail] <= nxt_ptr;
            slot_cnt[tail] <= nxt_count;
`ifdef RAS_CKPT_TOP_REPAIR_EN
            slot_top[tail] <= nxt_top;
`endif
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed and randomized checks of ras_ckpt against a queue-based reference model.
// Honours RAS_CKPT_TOP_REPAIR_EN the same way as the design.
module tb_ras_ckpt;

    localparam int E  = 8;
    localparam int N  = 4;
    localparam int TW = 31;
`ifdef RAS_CKPT_TOP_REPAIR_EN
    localparam bit REPAIR = 1'b1;
`else
    localparam bit REPAIR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          push_valid;
    logic [TW-1:0] push_target;
    logic          pop_valid;
    logic [TW-1:0] ret_target;
    logic          ret_hit;
    logic [2:0]    ras_ptr;
    logic          ckpt_save_valid;
    logic [1:0]    ckpt_save_id;
    logic          ckpt_full;
    logic          ckpt_free_valid;
    logic          restore_valid;
    logic [1:0]    restore_id;

    ras_ckpt #(.RAS_ENTRIES(E), .RAS_TARGET_WIDTH(TW), .RAS_CKPT_COUNT(N)) dut (
        .CLK(CLK), .RST(RST),
        .push_valid(push_valid), .push_target(push_target), .pop_valid(pop_valid),
        .ret_target(ret_target), .ret_hit(ret_hit), .ras_ptr(ras_ptr),
        .ckpt_save_valid(ckpt_save_valid), .ckpt_save_id(ckpt_save_id), .ckpt_full(ckpt_full),
        .ckpt_free_valid(ckpt_free_valid), .restore_valid(restore_valid), .restore_id(restore_id)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int            id;
        int            ptr;
        int            cnt;
        logic [TW-1:0] top;
    } ckpt_t;

    logic [TW-1:0] m_stack [E];
    int            m_ptr, m_cnt, m_tail;
    ckpt_t         q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input bit rst, input bit push, input logic [TW-1:0] pt,
                                       input bit pop, input bit save, input bit free,
                                       input bit rest, input int rid);
        bit    free_ok;
        bit    full;
        int    k;
        ckpt_t rec;
        if (rst) begin
            for (int i = 0; i < E; i++) m_stack[i] = '0;
            m_ptr = 0; m_cnt = 0; m_tail = 0;
            q.delete();
            return;
        end
        free_ok = free && (q.size() != 0);
        if (rest) begin
            k = 0;
            for (int i = 0; i < q.size(); i++) if (q[i].id == rid) k = i;
            rec   = q[k];
            m_ptr = rec.ptr;
            m_cnt = rec.cnt;
            if (REPAIR) m_stack[rec.ptr] = rec.top;
            while (q.size() > k + 1) void'(q.pop_back());
            m_tail = (rid + 1) % N;
            if (free_ok) void'(q.pop_front());
            return;
        end
        if (push && pop) begin
            m_stack[m_ptr] = pt;
            if (m_cnt == 0) m_cnt = 1;
        end else if (push) begin
            m_ptr = (m_ptr + 1) % E;
            m_stack[m_ptr] = pt;
            if (m_cnt < E) m_cnt++;
        end else if (pop && m_cnt > 0) begin
            m_ptr = (m_ptr + E - 1) % E;
            m_cnt--;
        end
        full = (q.size() == N);
        if (free_ok) void'(q.pop_front());
        if (save && (!full || free_ok)) begin
            rec.id = m_tail; rec.ptr = m_ptr; rec.cnt = m_cnt; rec.top = m_stack[m_ptr];
            q.push_back(rec);
            m_tail = (m_tail + 1) % N;
        end
    endfunction

    task automatic check_model();
        check("ret_target", 32'(ret_target), 32'(m_stack[m_ptr]));
        check("ret_hit", 32'(ret_hit), 32'(m_cnt != 0));
        check("ras_ptr", 32'(ras_ptr), 32'(m_ptr));
        check("ckpt_save_id", 32'(ckpt_save_id), 32'(m_tail));
        check("ckpt_full", 32'(ckpt_full), 32'(q.size() == N));
    endtask

    task automatic step(input bit rst, input bit push, input logic [TW-1:0] pt, input bit pop,
                        input bit save, input bit free, input bit rest, input int rid);
        RST = rst; push_valid = push; push_target = pt; pop_valid = pop;
        ckpt_save_valid = save; ckpt_free_valid = free;
        restore_valid = rest; restore_id = 2'(rid);
        @(posedge CLK);
        model_step(rst, push, pt, pop, save, free, rest, rid);
        #1;
        RST = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; ckpt_save_valid = 1'b0;
        ckpt_free_valid = 1'b0; restore_valid = 1'b0; restore_id = '0;
        check_model();
    endtask

    task automatic do_reset();            step(1, 0, '0, 0, 0, 0, 0, 0); endtask
    task automatic do_push(input int t);  step(0, 1, TW'(t), 0, 0, 0, 0, 0); endtask
    task automatic do_pop();              step(0, 0, '0, 1, 0, 0, 0, 0); endtask
    task automatic do_save();             step(0, 0, '0, 0, 1, 0, 0, 0); endtask
    task automatic do_free();             step(0, 0, '0, 0, 0, 1, 0, 0); endtask
    task automatic do_restore(input int id); step(0, 0, '0, 0, 0, 0, 1, id); endtask

    int            r, idx, rid;
    bit            b_rst, b_push, b_pop, b_save, b_free, b_rest;
    logic [TW-1:0] t;

    initial begin
        RST = 1'b1; push_valid = 1'b0; push_target = '0; pop_valid = 1'b0;
        ckpt_save_valid = 1'b0; ckpt_free_valid = 1'b0; restore_valid = 1'b0; restore_id = '0;
        #2;

        do_reset();
        check("rst_ret_target", 32'(ret_target), 32'h0);
        check("rst_ret_hit", 32'(ret_hit), 32'h0);
        check("rst_ras_ptr", 32'(ras_ptr), 32'h0);
        check("rst_save_id", 32'(ckpt_save_id), 32'h0);
        check("rst_full", 32'(ckpt_full), 32'h0);

        // basic push / pop
        do_push('h100); do_push('h200); do_push('h300);
        check("push3_target", 32'(ret_target), 32'h300);
        check("push3_ptr", 32'(ras_ptr), 32'd3);
        check("push3_hit", 32'(ret_hit), 32'd1);
        do_pop();  check("pop1_target", 32'(ret_target), 32'h200);
        do_pop();  check("pop2_target", 32'(ret_target), 32'h100);
        do_pop();  check("pop3_hit", 32'(ret_hit), 32'd0);
        do_pop();  check("pop4_hit", 32'(ret_hit), 32'd0);
        check("pop4_ptr", 32'(ras_ptr), 32'd0);

        // overflow wraps and drops the oldest entry
        do_reset();
        for (int i = 1; i <= 9; i++) do_push(i);
        check("ovf_target", 32'(ret_target), 32'd9);
        for (int i = 8; i >= 2; i--) begin
            do_pop();
            check("ovf_pop_target", 32'(ret_target), 32'(i));
            check("ovf_pop_hit", 32'(ret_hit), 32'd1);
        end
        do_pop();
        check("ovf_last_hit", 32'(ret_hit), 32'd0);

        // push and pop together replace the top
        do_reset();
        do_push('h40);
        step(0, 1, TW'('h44), 1, 0, 0, 0, 0);
        check("repl_target", 32'(ret_target), 32'h44);
        check("repl_ptr", 32'(ras_ptr), 32'd1);
        do_pop();
        check("repl_cnt1_hit", 32'(ret_hit), 32'd0);
        do_reset();
        step(0, 1, TW'('h55), 1, 0, 0, 0, 0);
        check("repl_empty_hit", 32'(ret_hit), 32'd1);
        check("repl_empty_target", 32'(ret_target), 32'h55);

        // checkpoint and restore
        do_reset();
        do_push('hA); do_save();
        do_push('hB); do_push('hC); do_save(); do_pop();
        do_restore(0);
        check("rest_target", 32'(ret_target), 32'hA);
        check("rest_save_id", 32'(ckpt_save_id), 32'd1);
        step(0, 1, TW'('h77), 0, 1, 0, 1, 0);
        check("rest_ovr_target", 32'(ret_target), 32'hA);
        check("rest_ovr_save_id", 32'(ckpt_save_id), 32'd1);
        check("rest_ovr_ptr", 32'(ras_ptr), 32'd1);
        do_save(); do_save();
        check("rest_cnt_notfull", 32'(ckpt_full), 32'd0);
        do_save();
        check("rest_cnt_full", 32'(ckpt_full), 32'd1);

        // checkpoint occupancy
        do_reset();
        for (int i = 0; i < 4; i++) do_save();
        check("occ_full", 32'(ckpt_full), 32'd1);
        do_save();
        check("occ_drop_id", 32'(ckpt_save_id), 32'd0);
        step(0, 0, '0, 0, 1, 1, 0, 0);
        check("occ_sf_full", 32'(ckpt_full), 32'd1);
        check("occ_sf_id", 32'(ckpt_save_id), 32'd1);
        for (int i = 0; i < 5; i++) do_free();
        check("occ_empty_full", 32'(ckpt_full), 32'd0);
        do_save();
        check("occ_after_id", 32'(ckpt_save_id), 32'd2);

        // top repair after a wrong-path overwrite
        do_reset();
        do_push('h10); do_save();
        do_pop(); do_push('h99);
        do_restore(0);
        check("repair_target", 32'(ret_target), REPAIR ? 32'h10 : 32'h99);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r      = int'($urandom_range(0, 199));
            b_rst  = (r == 0);
            b_push = ($urandom_range(0, 2) == 0);
            b_pop  = ($urandom_range(0, 2) == 0);
            b_save = ($urandom_range(0, 2) == 0);
            b_free = ($urandom_range(0, 3) == 0);
            b_rest = (q.size() != 0) && ($urandom_range(0, 11) == 0);
            rid    = 0;
            if (b_rest) begin
                idx = int'($urandom_range(0, q.size() - 1));
                rid = q[idx].id;
            end
            t = TW'($urandom());
            step(b_rst, b_push, t, b_pop, b_save, b_free, b_rest, rid);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
